// File: rtl/md5_pkg.sv
// Shared types and constants for the MD5 digest readout path.
package md5_pkg;

  localparam int unsigned DIGEST_W = 128;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned NBYTES   = DIGEST_W / BYTE_W;

  typedef enum logic [1:0] {
    IDLE,
    MANUAL,
    SCROLL
  } state_t;

  typedef logic [$clog2(NBYTES)-1:0] idx_t;

endpackage

// File: rtl/rise_detect.sv
// One-bit rising-edge detector for a debounced button level.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic prev;

  // Remember the level sampled at the previous clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev <= 1'b0;
    else      prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/digest_reader.sv
// Latches a digest and presents it one chunk at a time, either browsed
// with the shift buttons or scrolled automatically with a fixed dwell.
module digest_reader
  import md5_pkg::*;
#(
  parameter int unsigned WIDTH_IN    = 128,
  parameter int unsigned WIDTH_OUT   = 8,
  parameter int unsigned HOLD_CYCLES = 50000000
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [WIDTH_IN-1:0]                   digest_in,
  input  logic                                  digest_valid,
  input  logic                                  left_shift,
  input  logic                                  right_shift,
  input  logic                                  auto_mode,
  output logic [WIDTH_OUT-1:0]                  d_out,
  output logic [$clog2(WIDTH_IN/WIDTH_OUT)-1:0] idx,
  output logic                                  loaded,
  output logic                                  pass_done
);

  localparam int unsigned NBYTES = WIDTH_IN / WIDTH_OUT;
  localparam int unsigned IDX_W  = $clog2(NBYTES);
  localparam int unsigned CNT_W  = $clog2(HOLD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t              state;
  logic [WIDTH_IN-1:0] buffer;
  logic [CNT_W-1:0]    cnt;
  logic                left_rise;
  logic                right_rise;
  logic [IDX_W-1:0]    idx_nxt;
  logic [WIDTH_IN-1:0] buf_nxt;
  logic                wrap;

  rise_detect u_left (
    .clk   (clk),
    .rst   (rst),
    .level (left_shift),
    .rise  (left_rise)
  );

  rise_detect u_right (
    .clk   (clk),
    .rst   (rst),
    .level (right_shift),
    .rise  (right_rise)
  );

  // Next index and buffer contents; d_out is selected from these so it
  // changes on the same edge as idx instead of one cycle later.
  always_comb begin
    idx_nxt = idx;
    buf_nxt = buffer;
    wrap    = 1'b0;
    if (digest_valid) begin
      buf_nxt = digest_in;
      idx_nxt = '0;
    end else begin
      case (state)
        MANUAL: begin
          if (left_rise && !right_rise) begin
            if (idx != IDX_LAST) idx_nxt = idx + IDX_W'(1);
          end else if (right_rise && !left_rise) begin
            if (idx != '0) idx_nxt = idx - IDX_W'(1);
          end
        end
        SCROLL: begin
          if (auto_mode && cnt == CNT_LAST) begin
            if (idx == IDX_LAST) begin
              idx_nxt = '0;
              wrap    = 1'b1;
            end else begin
              idx_nxt = idx + IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Mode FSM, dwell counter and registered display outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      buffer    <= '0;
      cnt       <= '0;
      idx       <= '0;
      d_out     <= '0;
      loaded    <= 1'b0;
      pass_done <= 1'b0;
    end else begin
      buffer    <= buf_nxt;
      idx       <= idx_nxt;
      d_out     <= buf_nxt[idx_nxt*WIDTH_OUT +: WIDTH_OUT];
      pass_done <= wrap;
      if (digest_valid) begin
        loaded <= 1'b1;
        cnt    <= '0;
        state  <= auto_mode ? SCROLL : MANUAL;
      end else begin
        case (state)
          MANUAL: begin
            cnt <= '0;
            if (auto_mode) state <= SCROLL;
          end
          SCROLL: begin
            if (!auto_mode) begin
              state <= MANUAL;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              cnt <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: cnt <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_digest_reader.sv
// Bench for digest_reader with a short dwell of 4 cycles.
module tb_digest_reader;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] digest_in;
  logic         digest_valid;
  logic         left_shift;
  logic         right_shift;
  logic         auto_mode;
  logic [7:0]   d_out;
  logic [3:0]   idx;
  logic         loaded;
  logic         pass_done;

  digest_reader #(
    .WIDTH_IN    (128),
    .WIDTH_OUT   (8),
    .HOLD_CYCLES (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .digest_in    (digest_in),
    .digest_valid (digest_valid),
    .left_shift   (left_shift),
    .right_shift  (right_shift),
    .auto_mode    (auto_mode),
    .d_out        (d_out),
    .idx          (idx),
    .loaded       (loaded),
    .pass_done    (pass_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         l;
    logic         r;
    logic         a;
    logic         dv;
    logic [127:0] din;
    logic [3:0]   eidx;
    logic [7:0]   ed;
    logic         el;
    logic         epd;
  } vec_t;

  typedef struct {
    logic [3:0] idx;
    logic [7:0] d;
    logic       ld;
    logic       pd;
  } exp_t;

  localparam logic [127:0] DIG_A = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] DIG_B = 128'h8899AABBCCDDEEFF0011223344556677;

  vec_t         tbl[$];
  exp_t         sbq[$];
  logic [127:0] cur_d = '0;
  int           passed = 0;
  int           total = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Queue one vector; expected d_out is the digest byte at the expected index.
  task automatic v(input logic l, input logic r, input logic a, input logic dv,
                   input logic [127:0] din, input int ei, input logic el, input logic epd);
    vec_t t;
    logic [127:0] dd;
    if (dv) cur_d = din;
    dd     = cur_d;
    t.l    = l;
    t.r    = r;
    t.a    = a;
    t.dv   = dv;
    t.din  = din;
    t.eidx = 4'(ei);
    t.ed   = el ? dd[8*ei +: 8] : 8'h00;
    t.el   = el;
    t.epd  = epd;
    tbl.push_back(t);
  endtask

  task automatic run_tbl(input string nm);
    exp_t e;
    foreach (tbl[i]) begin
      left_shift   = tbl[i].l;
      right_shift  = tbl[i].r;
      auto_mode    = tbl[i].a;
      digest_valid = tbl[i].dv;
      digest_in    = tbl[i].din;
      sbq.push_back('{tbl[i].eidx, tbl[i].ed, tbl[i].el, tbl[i].epd});
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      chk($sformatf("%s[%0d].idx", nm, i), 128'(idx), 128'(e.idx));
      chk($sformatf("%s[%0d].d_out", nm, i), 128'(d_out), 128'(e.d));
      chk($sformatf("%s[%0d].loaded", nm, i), 128'(loaded), 128'(e.ld));
      chk($sformatf("%s[%0d].pass_done", nm, i), 128'(pass_done), 128'(e.pd));
    end
    tbl.delete();
  endtask

  initial begin
    rst          = 1'b0;
    digest_in    = '0;
    digest_valid = 1'b0;
    left_shift   = 1'b0;
    right_shift  = 1'b0;
    auto_mode    = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 4; i++) begin
      digest_in    = {$urandom, $urandom, $urandom, $urandom};
      digest_valid = 1'($urandom);
      left_shift   = 1'($urandom);
      right_shift  = 1'($urandom);
      auto_mode    = 1'($urandom);
      @(posedge clk);
      #1;
      chk("reset.idx", 128'(idx), 128'h0);
      chk("reset.d_out", 128'(d_out), 128'h0);
      chk("reset.loaded", 128'(loaded), 128'h0);
      chk("reset.pass_done", 128'(pass_done), 128'h0);
    end
    digest_valid = 1'b0;
    left_shift   = 1'b0;
    right_shift  = 1'b0;
    auto_mode    = 1'b0;
    rst          = 1'b1;

    // IDLE guard before any load
    v(1, 0, 0, 0, '0, 0, 0, 0);
    v(0, 1, 0, 0, '0, 0, 0, 0);
    v(1, 0, 1, 0, '0, 0, 0, 0);
    for (int k = 0; k < 6; k++) v(0, 0, 1, 0, '0, 0, 0, 0);
    v(0, 0, 0, 0, '0, 0, 0, 0);
    run_tbl("idle");

    // First load
    v(0, 0, 0, 1, DIG_A, 0, 1, 0);
    run_tbl("load");

    // Manual browse
    for (int k = 1; k <= 3; k++) begin
      v(1, 0, 0, 0, '0, k, 1, 0);
      v(0, 0, 0, 0, '0, k, 1, 0);
    end
    for (int k = 0; k < 20; k++) v(1, 0, 0, 0, '0, 4, 1, 0);
    v(0, 0, 0, 0, '0, 4, 1, 0);
    for (int k = 1; k <= 6; k++) begin
      v(0, 1, 0, 0, '0, (k > 4) ? 0 : 4 - k, 1, 0);
      v(0, 0, 0, 0, '0, (k > 4) ? 0 : 4 - k, 1, 0);
    end
    for (int k = 1; k <= 20; k++) begin
      v(1, 0, 0, 0, '0, (k > 15) ? 15 : k, 1, 0);
      v(0, 0, 0, 0, '0, (k > 15) ? 15 : k, 1, 0);
    end
    run_tbl("manual");

    // Simultaneous edges and load-over-button
    for (int k = 1; k <= 10; k++) begin
      v(0, 1, 0, 0, '0, 15 - k, 1, 0);
      v(0, 0, 0, 0, '0, 15 - k, 1, 0);
    end
    v(1, 1, 0, 0, '0, 5, 1, 0);
    v(0, 0, 0, 0, '0, 5, 1, 0);
    for (int k = 6; k <= 7; k++) begin
      v(1, 0, 0, 0, '0, k, 1, 0);
      v(0, 0, 0, 0, '0, k, 1, 0);
    end
    v(1, 0, 0, 1, DIG_B, 0, 1, 0);
    v(0, 0, 0, 0, '0, 0, 1, 0);
    v(1, 0, 0, 0, '0, 1, 1, 0);
    v(0, 0, 0, 0, '0, 1, 1, 0);
    v(0, 0, 0, 1, DIG_A, 0, 1, 0);
    run_tbl("simul");

    // Auto-scroll around the wrap, buttons ignored, then back to manual
    for (int k = 1; k <= 14; k++) begin
      v(1, 0, 0, 0, '0, k, 1, 0);
      v(0, 0, 0, 0, '0, k, 1, 0);
    end
    v(0, 0, 1, 0, '0, 14, 1, 0);
    for (int k = 0; k < 3; k++) v(0, 0, 1, 0, '0, 14, 1, 0);
    v(0, 0, 1, 0, '0, 15, 1, 0);
    for (int k = 0; k < 3; k++) v(0, 0, 1, 0, '0, 15, 1, 0);
    v(0, 0, 1, 0, '0, 0, 1, 1);
    v(1, 0, 1, 0, '0, 0, 1, 0);
    v(0, 0, 1, 0, '0, 0, 1, 0);
    v(0, 1, 1, 0, '0, 0, 1, 0);
    v(0, 0, 1, 0, '0, 1, 1, 0);
    v(1, 0, 1, 0, '0, 1, 1, 0);
    v(0, 0, 1, 0, '0, 1, 1, 0);
    v(0, 1, 1, 0, '0, 1, 1, 0);
    v(0, 0, 1, 0, '0, 2, 1, 0);
    v(0, 0, 0, 0, '0, 2, 1, 0);
    v(0, 0, 0, 0, '0, 2, 1, 0);
    v(1, 0, 0, 0, '0, 3, 1, 0);
    v(0, 0, 0, 0, '0, 3, 1, 0);
    v(0, 1, 0, 0, '0, 2, 1, 0);
    v(0, 0, 0, 0, '0, 2, 1, 0);
    run_tbl("scroll");

    // Load straight into SCROLL and run up to index 9
    v(0, 0, 1, 1, DIG_A, 0, 1, 0);
    for (int k = 1; k <= 36; k++) v(0, 0, 1, 0, '0, k / 4, 1, 0);
    run_tbl("toidx9");

    // Asynchronous reset between clock edges
    #2;
    rst = 1'b0;
    #1;
    chk("arst.idx", 128'(idx), 128'h0);
    chk("arst.d_out", 128'(d_out), 128'h0);
    chk("arst.loaded", 128'(loaded), 128'h0);
    chk("arst.pass_done", 128'(pass_done), 128'h0);
    @(posedge clk);
    #1;
    rst   = 1'b1;
    cur_d = '0;

    // After release: IDLE, buttons and auto_mode ignored
    v(1, 0, 1, 0, '0, 0, 0, 0);
    v(0, 0, 1, 0, '0, 0, 0, 0);
    v(0, 1, 1, 0, '0, 0, 0, 0);
    for (int k = 0; k < 6; k++) v(0, 0, 1, 0, '0, 0, 0, 0);
    v(0, 0, 1, 1, DIG_B, 0, 1, 0);
    for (int k = 1; k <= 4; k++) v(0, 0, 1, 0, '0, k / 4, 1, 0);
    run_tbl("postrst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
